// File: rtl/execute_feedback_merge.sv
// execute_feedback_merge: routes the per-unit execute feedback channels into one ordered pack,
// with a popcount of enabled channels and a sticky duplicate-phy_id monitor. Optional macro
// EXECUTE_FEEDBACK_OUTPUT_REG_EN registers the pack and count for one cycle of latency.
package execute_feedback_pkg;
  localparam int PHY_REG_ID_WIDTH = 6;
  localparam int ALU_UNIT_NUM     = 2;
  localparam int BRU_UNIT_NUM     = 1;
  localparam int CSR_UNIT_NUM     = 1;
  localparam int DIV_UNIT_NUM     = 1;
  localparam int LSU_UNIT_NUM     = 1;
  localparam int MUL_UNIT_NUM     = 2;
  localparam int EXECUTE_FEEDBACK_CHANNEL_NUM = ALU_UNIT_NUM + BRU_UNIT_NUM + CSR_UNIT_NUM +
                                                DIV_UNIT_NUM + LSU_UNIT_NUM + MUL_UNIT_NUM;
  localparam int FEEDBACK_COUNT_WIDTH = 4;

  typedef struct packed {
    logic                        enable;
    logic [PHY_REG_ID_WIDTH-1:0] phy_id;
    logic [31:0]                 value;
  } execute_feedback_channel_t;

  typedef struct packed {
    execute_feedback_channel_t [EXECUTE_FEEDBACK_CHANNEL_NUM-1:0] channel;
  } execute_feedback_pack_t;
endpackage

module execute_feedback_merge
  import execute_feedback_pkg::*;
(
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  execute_feedback_channel_t [ALU_UNIT_NUM-1:0] alu_execute_channel_feedback_pack,
  input  execute_feedback_channel_t [BRU_UNIT_NUM-1:0] bru_execute_channel_feedback_pack,
  input  execute_feedback_channel_t [CSR_UNIT_NUM-1:0] csr_execute_channel_feedback_pack,
  input  execute_feedback_channel_t [DIV_UNIT_NUM-1:0] div_execute_channel_feedback_pack,
  input  execute_feedback_channel_t [LSU_UNIT_NUM-1:0] lsu_execute_channel_feedback_pack,
  input  execute_feedback_channel_t [MUL_UNIT_NUM-1:0] mul_execute_channel_feedback_pack,
  output execute_feedback_pack_t                       execute_feedback_pack,
  output logic [FEEDBACK_COUNT_WIDTH-1:0]              feedback_valid_count,
  output logic                                         dup_phy_id_err
);

  localparam int TOTAL    = EXECUTE_FEEDBACK_CHANNEL_NUM;
  localparam int BRU_BASE = ALU_UNIT_NUM;
  localparam int CSR_BASE = BRU_BASE + BRU_UNIT_NUM;
  localparam int DIV_BASE = CSR_BASE + CSR_UNIT_NUM;
  localparam int LSU_BASE = DIV_BASE + DIV_UNIT_NUM;
  localparam int MUL_BASE = LSU_BASE + LSU_UNIT_NUM;

  execute_feedback_pack_t            merged_pack;
  logic [FEEDBACK_COUNT_WIDTH-1:0]   merged_count;
  logic                              dup_hit;

  // Fixed channel order; disabled channels are copied verbatim so the pack is pure routing.
  always_comb begin
    merged_pack = '0;
    for (int i = 0; i < ALU_UNIT_NUM; i++) merged_pack.channel[i]          = alu_execute_channel_feedback_pack[i];
    for (int i = 0; i < BRU_UNIT_NUM; i++) merged_pack.channel[BRU_BASE+i] = bru_execute_channel_feedback_pack[i];
    for (int i = 0; i < CSR_UNIT_NUM; i++) merged_pack.channel[CSR_BASE+i] = csr_execute_channel_feedback_pack[i];
    for (int i = 0; i < DIV_UNIT_NUM; i++) merged_pack.channel[DIV_BASE+i] = div_execute_channel_feedback_pack[i];
    for (int i = 0; i < LSU_UNIT_NUM; i++) merged_pack.channel[LSU_BASE+i] = lsu_execute_channel_feedback_pack[i];
    for (int i = 0; i < MUL_UNIT_NUM; i++) merged_pack.channel[MUL_BASE+i] = mul_execute_channel_feedback_pack[i];
  end

  // NOTE: every always_comb output gets a default before the loop so no path can infer a latch.
  always_comb begin
    merged_count = '0;
    for (int i = 0; i < TOTAL; i++)
      merged_count = merged_count + FEEDBACK_COUNT_WIDTH'(merged_pack.channel[i].enable);
  end

`ifdef EXECUTE_FEEDBACK_OUTPUT_REG_EN
  execute_feedback_pack_t          pack_q;
  logic [FEEDBACK_COUNT_WIDTH-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pack_q  <= '0;
      count_q <= '0;
    end else begin
      pack_q  <= merged_pack;
      count_q <= merged_count;
    end
  end

  assign execute_feedback_pack = pack_q;
  assign feedback_valid_count  = count_q;
`else
  assign execute_feedback_pack = merged_pack;
  assign feedback_valid_count  = merged_count;
`endif

  // The monitor watches whatever the consumer sees, so in registered mode it lags one more cycle.
  always_comb begin
    dup_hit = 1'b0;
    for (int j = 0; j < TOTAL - 1; j++) begin
      for (int k = j + 1; k < TOTAL; k++) begin
        if (execute_feedback_pack.channel[j].enable && execute_feedback_pack.channel[k].enable &&
            (execute_feedback_pack.channel[j].phy_id == execute_feedback_pack.channel[k].phy_id))
          dup_hit = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      dup_phy_id_err <= 1'b0;
    else if (dup_hit)
      dup_phy_id_err <= 1'b1;
  end

endmodule

// File: tb/tb_execute_feedback_merge.sv
// Self-checking bench for execute_feedback_merge: directed vector table, hand-written reset and
// duplicate sequences, then randomized cycles against a set-based reference model.
module tb_execute_feedback_merge;
  import execute_feedback_pkg::*;

`ifdef EXECUTE_FEEDBACK_OUTPUT_REG_EN
  localparam bit REG_MODE = 1'b1;
`else
  localparam bit REG_MODE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  execute_feedback_channel_t [ALU_UNIT_NUM-1:0] alu;
  execute_feedback_channel_t [BRU_UNIT_NUM-1:0] bru;
  execute_feedback_channel_t [CSR_UNIT_NUM-1:0] csr;
  execute_feedback_channel_t [DIV_UNIT_NUM-1:0] div;
  execute_feedback_channel_t [LSU_UNIT_NUM-1:0] lsu;
  execute_feedback_channel_t [MUL_UNIT_NUM-1:0] mul;
  execute_feedback_pack_t pack;
  logic [3:0] count;
  logic       err;

  execute_feedback_merge dut (
    .clk                               (clk),
    .rst_n                             (rst_n),
    .alu_execute_channel_feedback_pack (alu),
    .bru_execute_channel_feedback_pack (bru),
    .csr_execute_channel_feedback_pack (csr),
    .div_execute_channel_feedback_pack (div),
    .lsu_execute_channel_feedback_pack (lsu),
    .mul_execute_channel_feedback_pack (mul),
    .execute_feedback_pack             (pack),
    .feedback_valid_count              (count),
    .dup_phy_id_err                    (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic execute_feedback_channel_t ch(input logic en, input int id, input logic [31:0] v);
    ch.enable = en;
    ch.phy_id = PHY_REG_ID_WIDTH'(id);
    ch.value  = v;
  endfunction

  // Channel index -> unit port, straight from the documented ordering.
  task automatic drive(input execute_feedback_pack_t s);
    alu[0] = s.channel[0];
    alu[1] = s.channel[1];
    bru[0] = s.channel[2];
    csr[0] = s.channel[3];
    div[0] = s.channel[4];
    lsu[0] = s.channel[5];
    mul[0] = s.channel[6];
    mul[1] = s.channel[7];
  endtask

  function automatic int model_count(input execute_feedback_pack_t p);
    int n = 0;
    for (int i = 0; i < 8; i++) if (p.channel[i].enable) n++;
    return n;
  endfunction

  function automatic logic model_dup(input execute_feedback_pack_t p);
    bit seen [64];
    logic d = 1'b0;
    for (int i = 0; i < 64; i++) seen[i] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (p.channel[i].enable) begin
        if (seen[p.channel[i].phy_id]) d = 1'b1;
        seen[p.channel[i].phy_id] = 1'b1;
      end
    end
    return d;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string                  name;
    execute_feedback_pack_t stim;
    logic [3:0]             exp_count;
    logic                   exp_err;
  } vec_t;

  vec_t vecs [6];
  execute_feedback_pack_t zero_pack;
  execute_feedback_pack_t s;
  execute_feedback_pack_t vis;
  logic exp_err;

  initial begin
    zero_pack = '0;
    rst_n = 1'b0;
    drive(zero_pack);

    s = '0; s.channel[0] = ch(1, 5, 32'h1234); s.channel[1] = ch(0, 3, 32'hdead);
    vecs[0] = '{"alu_pass", s, 4'd1, 1'b0};
    s = '0; s.channel[2] = ch(1, 7, 32'hA); s.channel[3] = ch(1, 8, 32'hB);
    s.channel[4] = ch(1, 9, 32'hC); s.channel[5] = ch(1, 10, 32'hD); s.channel[7] = ch(1, 11, 32'hE);
    vecs[1] = '{"unit_order", s, 4'd5, 1'b0};
    s = '0; for (int i = 0; i < 8; i++) s.channel[i] = ch(1, i, 32'hFFFF_FFFF);
    vecs[2] = '{"all_enabled", s, 4'd8, 1'b0};
    s = '0; s.channel[0] = ch(1, 20, 32'h1); s.channel[2] = ch(0, 20, 32'h2);
    vecs[3] = '{"dup_one_disabled", s, 4'd1, 1'b0};
    s = '0; for (int i = 0; i < 8; i++) s.channel[i] = ch(0, 3 * i + 1, 32'hC0DE_0000 + i);
    vecs[4] = '{"all_disabled", s, 4'd0, 1'b0};
    s = '0; s.channel[0] = ch(1, 12, 32'h11); s.channel[5] = ch(1, 12, 32'h22);
    vecs[5] = '{"dup_alu_lsu", s, 4'd2, 1'b1};

    #1;
    check("reset_err", {511'd0, err}, 512'd0);
    check("reset_pack", 512'(pack), 512'd0);
    check("reset_count", 512'(count), 512'd0);
    #6 rst_n = 1'b1;

    // Directed table: two edges per vector so both build variants have settled pack and flag.
    for (int v = 0; v < 6; v++) begin
      @(negedge clk);
      drive(vecs[v].stim);
      step();
      step();
      check({vecs[v].name, "_pack"}, 512'(pack), 512'(vecs[v].stim));
      check({vecs[v].name, "_count"}, 512'(count), 512'(vecs[v].exp_count));
      check({vecs[v].name, "_err"}, 512'(err), 512'(vecs[v].exp_err));
    end

    // Flag is sticky once inputs are clean again.
    @(negedge clk);
    drive(vecs[2].stim);
    step();
    step();
    check("sticky_err", 512'(err), 512'd1);

    // Asynchronous reset mid-cycle clears the flag with no clock edge.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_err", 512'(err), 512'd0);
    check("rst_pack", 512'(pack), REG_MODE ? 512'd0 : 512'(vecs[2].stim));
    check("rst_count", 512'(count), REG_MODE ? 512'd0 : 512'd8);
    #1 rst_n = 1'b1;

    // phy_id 0 is an ordinary id for the monitor.
    @(negedge clk);
    s = '0; s.channel[3] = ch(1, 0, 32'h5); s.channel[4] = ch(1, 0, 32'h6);
    drive(s);
    step();
    step();
    check("id0_count", 512'(count), 512'd2);
    check("id0_err", 512'(err), 512'd1);

    // Registered build: output lags the input by exactly one edge.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    s = '0; s.channel[0] = ch(1, 5, 32'h1234);
    drive(s);
    #1;
    check("latency_before_edge", 512'(pack), REG_MODE ? 512'd0 : 512'(s));
    step();
    check("latency_after_edge", 512'(pack), 512'(s));
    check("latency_count", 512'(count), 512'd1);

    // Randomized cycles against the set-based model.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    exp_err = 1'b0;
    vis = '0;
    for (int it = 0; it < 400; it++) begin
      int mode;
      @(negedge clk);
      mode = $urandom_range(0, 2);
      for (int i = 0; i < 8; i++) begin
        int id;
        if (mode == 0)      id = $urandom_range(0, 7);
        else if (mode == 1) id = $urandom_range(0, 63);
        else                id = i + 8 * $urandom_range(0, 7);
        s.channel[i] = ch(($urandom_range(0, 3) != 0), id, $urandom);
      end
      drive(s);
      if (it % 16 == 0) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        exp_err = 1'b0;
        if (REG_MODE) vis = '0;
      end
      step();
      if (REG_MODE) begin
        exp_err = exp_err | model_dup(vis);
        vis = s;
      end else begin
        exp_err = exp_err | model_dup(s);
        vis = s;
      end
      check("rand_pack", 512'(pack), 512'(vis));
      check("rand_count", 512'(count), 512'(model_count(vis)));
      check("rand_err", 512'(err), 512'(exp_err));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
